// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of the single-port byte-enabled bram: fetch port A (read-only), data port B (read/write).
// Optional A starvation guard compiled in with `define BRAM_ARB_STARVE_EN.
module bram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-3:0] a_addr,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [31:0]           a_rdata,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-3:0] b_addr,
  input  logic [3:0]            b_we,
  input  logic [31:0]           b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [31:0]           b_rdata,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_cs_n,
  output logic [3:0]            mem_we_n,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef struct packed {
    logic vld;
    logic owner_b;
  } rtag_t;

  logic  w_a_pri;
  logic  w_a_gnt;
  logic  w_b_gnt;
  logic  w_b_wr;
  logic  w_a_rvalid;
  logic  w_b_rvalid;
  rtag_t r_rtag;
  logic [31:0] r_a_hold;
  logic [31:0] r_b_hold;

`ifdef BRAM_ARB_STARVE_EN
  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_a;

  // NOTE: reset is synchronous, so it lives inside the clocked branch; all state uses <= to avoid ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_a <= '0;
    end else if (a_req && !w_a_gnt) begin
      if (r_wait_a != WAIT_MAX) r_wait_a <= r_wait_a + WAIT_W'(1);
    end else begin
      r_wait_a <= '0;
    end
  end

  assign w_a_pri = (r_wait_a == WAIT_MAX);
`else
  assign w_a_pri = 1'b0;
`endif

  // B wins by default; A wins only once its wait counter has saturated.
  assign w_b_gnt = !reset && b_req && !(a_req && w_a_pri);
  assign w_a_gnt = !reset && a_req && !w_b_gnt;
  assign w_b_wr  = |b_we;

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  // NOTE: every output gets an idle default first so no path through this block can infer a latch.
  always_comb begin
    mem_addr  = '0;
    mem_cs_n  = 4'b1111;
    mem_we_n  = 4'b1111;
    mem_wdata = '0;
    if (w_a_gnt) begin
      mem_addr = a_addr;
      mem_cs_n = 4'b0000;
    end else if (w_b_gnt) begin
      mem_addr = b_addr;
      if (w_b_wr) begin
        mem_cs_n  = ~b_we;
        mem_we_n  = ~b_we;
        mem_wdata = b_wdata;
      end else begin
        mem_cs_n = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rtag <= '0;
    end else begin
      r_rtag.vld     <= w_a_gnt || (w_b_gnt && !w_b_wr);
      r_rtag.owner_b <= w_b_gnt;
    end
  end

  // Gating with reset drops a return whose grant preceded a reset cycle.
  assign w_a_rvalid = r_rtag.vld && !r_rtag.owner_b && !reset;
  assign w_b_rvalid = r_rtag.vld &&  r_rtag.owner_b && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_hold <= '0;
      r_b_hold <= '0;
    end else begin
      if (w_a_rvalid) r_a_hold <= mem_rdata;
      if (w_b_rvalid) r_b_hold <= mem_rdata;
    end
  end

  assign a_rvalid = w_a_rvalid;
  assign b_rvalid = w_b_rvalid;
  assign a_rdata  = w_a_rvalid ? mem_rdata : r_a_hold;
  assign b_rdata  = w_b_rvalid ? mem_rdata : r_b_hold;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter with a byte-enabled registered-read bram model.
module tb_bram_arbiter;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, b_req;
  logic [AW-3:0] a_addr, b_addr;
  logic [3:0]    b_we;
  logic [31:0]   b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_cs_n, mem_we_n;
  logic [31:0]   mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:(1<<(AW-2))-1];

  always #5 clk = ~clk;

  bram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // bram: per-byte active-low selects, registered read, byte writes on the same edge.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!mem_cs_n[i] && !mem_we_n[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      if (!mem_cs_n[i] &&  mem_we_n[i]) mem_rdata[8*i +: 8] <= mem[mem_addr][8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; b_req = 1'b0; b_we = 4'b0000; b_wdata = '0;
  endtask

  initial begin
    logic exp_a;
    for (int i = 0; i < (1<<(AW-2)); i++) mem[i] = '0;
    mem[0] = 32'hCAFE0000;
    mem[1] = 32'hA1A10001;
    mem[2] = 32'hB2B20002;
    mem[3] = 32'hA3A30003;
    mem[5] = 32'hDEADBEEF;
    mem_rdata = '0;

    // Reset held three cycles with both ports requesting.
    reset = 1'b1;
    a_req = 1'b1; a_addr = 10'd7; b_req = 1'b1; b_addr = 10'd0; b_we = 4'b0000; b_wdata = '0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_a_gnt", 32'(a_gnt), 32'd0);
      check("rst_b_gnt", 32'(b_gnt), 32'd0);
      check("rst_cs_n", 32'(mem_cs_n), 32'hF);
      check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
      next_cycle();
    end
    check("rst_a_rdata", a_rdata, 32'd0);

    // First cycle out of reset: B wins.
    reset = 1'b0;
    @(negedge clk);
    check("first_b_gnt", 32'(b_gnt), 32'd1);
    check("first_a_gnt", 32'(a_gnt), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("first_b_rvalid", 32'(b_rvalid), 32'd1);
    check("first_b_rdata", b_rdata, 32'hCAFE0000);
    check("idle_cs_n", 32'(mem_cs_n), 32'hF);
    next_cycle();

    // A-only read of word 5.
    a_req = 1'b1; a_addr = 10'd5;
    @(negedge clk);
    check("aread_gnt", 32'(a_gnt), 32'd1);
    check("aread_cs_n", 32'(mem_cs_n), 32'h0);
    check("aread_we_n", 32'(mem_we_n), 32'hF);
    check("aread_addr", 32'(mem_addr), 32'd5);
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    check("aread_rvalid", 32'(a_rvalid), 32'd1);
    check("aread_rdata", a_rdata, 32'hDEADBEEF);
    check("aread_b_rvalid", 32'(b_rvalid), 32'd0);
    next_cycle();

    // Byte-lane 2 write to word 5, then B read-back.
    b_req = 1'b1; b_addr = 10'd5; b_we = 4'b0100; b_wdata = 32'h00AB0000;
    @(negedge clk);
    check("bwr_gnt", 32'(b_gnt), 32'd1);
    check("bwr_cs_n", 32'(mem_cs_n), 32'hB);
    check("bwr_we_n", 32'(mem_we_n), 32'hB);
    check("bwr_wdata", mem_wdata, 32'h00AB0000);
    next_cycle();
    b_we = 4'b0000; b_wdata = '0;
    @(negedge clk);
    check("bwr_no_rvalid", 32'(b_rvalid), 32'd0);
    check("brd_cs_n", 32'(mem_cs_n), 32'h0);
    next_cycle();
    b_req = 1'b0;
    @(negedge clk);
    check("brd_rvalid", 32'(b_rvalid), 32'd1);
    check("brd_rdata", b_rdata, 32'hDEABBEEF);
    check("a_rdata_hold", a_rdata, 32'hDEADBEEF);
    next_cycle();

    // Continuous contention for ten cycles.
    a_req = 1'b1; a_addr = 10'd1; b_req = 1'b1; b_addr = 10'd2;
    for (int k = 1; k <= 10; k++) begin
`ifdef BRAM_ARB_STARVE_EN
      exp_a = (k % 5 == 0);
`else
      exp_a = 1'b0;
`endif
      @(negedge clk);
      check($sformatf("cont_a_gnt_%0d", k), 32'(a_gnt), 32'(exp_a));
      check($sformatf("cont_b_gnt_%0d", k), 32'(b_gnt), 32'(!exp_a));
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Interleaved A/B/A reads.
    a_req = 1'b1; a_addr = 10'd1;
    @(negedge clk);
    check("il_a1_gnt", 32'(a_gnt), 32'd1);
    next_cycle();
    a_req = 1'b0; b_req = 1'b1; b_addr = 10'd2;
    @(negedge clk);
    check("il_b2_gnt", 32'(b_gnt), 32'd1);
    check("il_a1_rvalid", 32'(a_rvalid), 32'd1);
    check("il_a1_rdata", a_rdata, 32'hA1A10001);
    check("il_a1_b_rvalid", 32'(b_rvalid), 32'd0);
    next_cycle();
    b_req = 1'b0; a_req = 1'b1; a_addr = 10'd3;
    @(negedge clk);
    check("il_a3_gnt", 32'(a_gnt), 32'd1);
    check("il_b2_rvalid", 32'(b_rvalid), 32'd1);
    check("il_b2_rdata", b_rdata, 32'hB2B20002);
    check("il_b2_a_rvalid", 32'(a_rvalid), 32'd0);
    check("il_a_hold", a_rdata, 32'hA1A10001);
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    check("il_a3_rvalid", 32'(a_rvalid), 32'd1);
    check("il_a3_rdata", a_rdata, 32'hA3A30003);
    check("il_b_hold", b_rdata, 32'hB2B20002);
    next_cycle();

    // Reset in the cycle after an A read grant, with a B write pending.
    a_req = 1'b1; a_addr = 10'd5;
    @(negedge clk);
    check("mr_a_gnt", 32'(a_gnt), 32'd1);
    next_cycle();
    reset = 1'b1; a_req = 1'b0;
    b_req = 1'b1; b_addr = 10'd5; b_we = 4'b1111; b_wdata = 32'h12345678;
    @(negedge clk);
    check("mr_a_rvalid", 32'(a_rvalid), 32'd0);
    check("mr_b_gnt", 32'(b_gnt), 32'd0);
    check("mr_we_n", 32'(mem_we_n), 32'hF);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("mr_after_a_rvalid", 32'(a_rvalid), 32'd0);
    check("mr_after_a_rdata", a_rdata, 32'd0);
    next_cycle();
    a_req = 1'b1; a_addr = 10'd5;
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    check("mr_word5_rvalid", 32'(a_rvalid), 32'd1);
    check("mr_word5_kept", a_rdata, 32'hDEABBEEF);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
